fetch_unit: RTL and testbench

//  Program-counter and fetch-control stage feeding the word-addressed instruction memory.

---
 rtl/core_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TRAPPED = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for fetch performance statistics.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, next-PC selection and fetch sequencing FSM.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = core_pkg::RESET_PC_DEFAULT,
  parameter int          IMEM_ADDR_W = 10,
  parameter logic [31:0] NOP_INST    = core_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_target_i,
  input  logic                   halt_i,
  input  logic [31:0]            imem_inst_i,
  output logic [IMEM_ADDR_W-1:0] imem_addr_o,
  output logic [31:0]            pc_o,
  output logic [31:0]            pc_plus4_o,
  output logic [31:0]            inst_o,
  output logic                   inst_valid_o,
  output logic                   misaligned_o,
  output logic [1:0]             state_o,
  output logic [31:0]            fetch_count_o,
  output logic [31:0]            redirect_count_o
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         run;
  logic         bad_tgt;
  logic         fetch_inc;
  logic         redir_inc;

  assign run       = (state == RUN);
  assign bad_tgt   = (redirect_target_i[1:0] != 2'b00);
  assign fetch_inc = run && !halt_i && !stall_i;
  assign redir_inc = fetch_inc && redirect_i && !bad_tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misaligned_o <= 1'b0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (halt_i) begin
            state <= HALTED;
          end else if (stall_i) begin
            pc <= pc;
          end else if (redirect_i && bad_tgt) begin
            state        <= TRAPPED;
            misaligned_o <= 1'b1;
          end else if (redirect_i) begin
            pc <= redirect_target_i;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        HALTED, TRAPPED: state <= state;
        default: state <= state;
      endcase
    end
  end

  // Upper PC bits simply alias onto the memory; no range fault.
  assign imem_addr_o  = pc[IMEM_ADDR_W+1:2];
  assign pc_o         = pc;
  assign pc_plus4_o   = pc + 32'd4;
  assign inst_valid_o = run;
  assign inst_o       = run ? imem_inst_i : NOP_INST;
  assign state_o      = state;

`ifdef FETCH_PERF_CNT_EN
  sat_counter #(.WIDTH(32)) u_fetch_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fetch_inc),
    .count (fetch_count_o)
  );

  sat_counter #(.WIDTH(32)) u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redir_inc),
    .count (redirect_count_o)
  );
`else
  assign fetch_count_o    = 32'h0;
  assign redirect_count_o = 32'h0;
  logic unused_cnt;
  assign unused_cnt = redir_inc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_target_i = 32'h0;
  logic        halt_i = 1'b0;
  logic [31:0] imem_inst_i = 32'hDEAD_BEEF;
  logic [9:0]  imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        misaligned_o;
  logic [1:0]  state_o;
  logic [31:0] fetch_count_o;
  logic [31:0] redirect_count_o;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .halt_i            (halt_i),
    .imem_inst_i       (imem_inst_i),
    .imem_addr_o       (imem_addr_o),
    .pc_o              (pc_o),
    .pc_plus4_o        (pc_plus4_o),
    .inst_o            (inst_o),
    .inst_valid_o      (inst_valid_o),
    .misaligned_o      (misaligned_o),
    .state_o           (state_o),
    .fetch_count_o     (fetch_count_o),
    .redirect_count_o  (redirect_count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_core(input string tag, input logic [1:0] st,
                          input logic [31:0] pc, input logic vld);
    chk({tag, ".state"}, {30'h0, state_o}, {30'h0, st});
    chk({tag, ".pc"}, pc_o, pc);
    chk({tag, ".addr"}, {22'h0, imem_addr_o}, {22'h0, pc[11:2]});
    chk({tag, ".pc4"}, pc_plus4_o, pc + 32'd4);
    chk({tag, ".valid"}, {31'h0, inst_valid_o}, {31'h0, vld});
    chk({tag, ".inst"}, inst_o, vld ? imem_inst_i : 32'h0000_0013);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk_core("rst", 2'd0, 32'h0, 1'b0);
    chk("rst.mis", {31'h0, misaligned_o}, 32'h0);
    chk("rst.fc", fetch_count_o, 32'h0);
    chk("rst.rc", redirect_count_o, 32'h0);

    // 1: boot then sequential fetch
    rst = 1'b0;
    chk_core("t1.c0", 2'd0, 32'h0, 1'b0);
    @(negedge clk);
    chk_core("t1.c1", 2'd1, 32'h0, 1'b1);
    @(negedge clk);
    chk_core("t1.c2", 2'd1, 32'h4, 1'b1);
    imem_inst_i = 32'h1234_5678;
    @(negedge clk);
    chk_core("t1.c3", 2'd1, 32'h8, 1'b1);
    chk("t1.fc", fetch_count_o, cnt(32'd2));
    repeat (3) @(negedge clk);
    chk("t2.pre", pc_o, 32'h14);

    // 2: aligned redirect
    redirect_i = 1'b1;
    redirect_target_i = 32'h1C;
    @(negedge clk);
    chk_core("t2", 2'd1, 32'h1C, 1'b1);
    chk("t2.addr7", {22'h0, imem_addr_o}, 32'd7);
    chk("t2.rc", redirect_count_o, cnt(32'd1));
    chk("t2.fc", fetch_count_o, cnt(32'd6));

    // 3: stall dominates redirect
    stall_i = 1'b1;
    redirect_target_i = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3.pc", pc_o, 32'h1C);
      chk("t3.fc", fetch_count_o, cnt(32'd6));
      chk("t3.rc", redirect_count_o, cnt(32'd1));
    end
    stall_i = 1'b0;
    @(negedge clk);
    chk_core("t3.go", 2'd1, 32'h40, 1'b1);
    chk("t3.fc2", fetch_count_o, cnt(32'd7));
    chk("t3.rc2", redirect_count_o, cnt(32'd2));

    // 6: wrap-around and async reset
    redirect_target_i = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("t6.top", pc_o, 32'hFFFF_FFFC);
    chk("t6.p4", pc_plus4_o, 32'h0);
    @(negedge clk);
    chk_core("t6.wrap", 2'd1, 32'h0, 1'b1);
    chk("t6.fc", fetch_count_o, cnt(32'd9));
    @(negedge clk);
    chk("t6.pc4", pc_o, 32'h4);
    #2 rst = 1'b1;
    #1;
    chk("t6.arst.pc", pc_o, 32'h0);
    chk("t6.arst.st", {30'h0, state_o}, 32'h0);
    chk("t6.arst.fc", fetch_count_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 4: misaligned redirect traps
    @(negedge clk);
    chk_core("t4.run", 2'd1, 32'h0, 1'b1);
    redirect_i = 1'b1;
    redirect_target_i = 32'h22;
    @(negedge clk);
    chk_core("t4.trap", 2'd3, 32'h0, 1'b0);
    chk("t4.mis", {31'h0, misaligned_o}, 32'h1);
    chk("t4.rc", redirect_count_o, cnt(32'd0));
    chk("t4.fc", fetch_count_o, cnt(32'd1));
    redirect_target_i = 32'h80;
    repeat (2) @(negedge clk);
    chk_core("t4.stick", 2'd3, 32'h0, 1'b0);
    chk("t4.mis2", {31'h0, misaligned_o}, 32'h1);
    redirect_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("t4.clr.mis", {31'h0, misaligned_o}, 32'h0);
    chk("t4.clr.st", {30'h0, state_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 5: halt beats redirect, then terminal
    repeat (2) @(negedge clk);
    chk("t5.pre", pc_o, 32'h4);
    halt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_target_i = 32'h80;
    @(negedge clk);
    chk_core("t5.halt", 2'd2, 32'h4, 1'b0);
    halt_i = 1'b0;
    repeat (2) @(negedge clk);
    chk_core("t5.hold", 2'd2, 32'h4, 1'b0);
    chk("t5.fc", fetch_count_o, cnt(32'd1));
    chk("t5.rc", redirect_count_o, cnt(32'd0));
    redirect_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
